// File: rtl/dmem_wait_responder.sv
// Word-addressed data memory responder with a fixed number of wait states, access
// error flagging and a saturating count of completed writes.
`timescale 1ns/1ps

module dmem_wait_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNTW    = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  output logic            ready_o,
  output logic            ack_o,
  output logic            err_o,
  output logic [31:0]     rdata_o,
  output logic [CNTW-1:0] wr_count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            ready_q, ready_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CNTW-1:0] wr_count_q, wr_count_d;

  logic [31:0]     mem_q [DEPTH];

  // operation operands: live inputs when RESP is entered straight from IDLE
  logic            op_we_c;
  logic [31:0]     op_addr_c;
  logic [31:0]     op_wdata_c;
  logic            op_legal_c;
  logic [AW-1:0]   op_idx_c;
  logic            enter_resp_c;
  logic            mem_we_c;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    rdata_d      = 32'd0;
    wr_count_d   = wr_count_q;
    mem_we_c     = 1'b0;
    op_we_c      = we_q;
    op_addr_c    = addr_q;
    op_wdata_c   = wdata_q;

    case (state_q)
      S_IDLE: begin
        op_we_c    = we_i;
        op_addr_c  = addr_i;
        op_wdata_c = wdata_i;
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    op_legal_c   = (op_addr_c[1:0] == 2'b00) && (op_addr_c[31:2] < 30'(DEPTH));
    op_idx_c     = op_addr_c[AW+1:2];
    enter_resp_c = (state_d == S_RESP) && (state_q != S_RESP);

    // memory access and response payload are produced on the edge entering RESP
    if (enter_resp_c) begin
      ack_d = 1'b1;
      err_d = !op_legal_c;
      if (op_legal_c && op_we_c) begin
        mem_we_c = 1'b1;
        if (wr_count_q != {CNTW{1'b1}}) begin
          wr_count_d = wr_count_q + CNTW'(1);
        end
      end else if (op_legal_c) begin
        rdata_d = mem_q[op_idx_c];
      end
    end

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      ready_q    <= 1'b1;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      wr_count_q <= wr_count_d;
    end
  end

  // storage survives reset; an aborted operation never reaches RESP so never writes
  always_ff @(posedge clk_i) begin
    if (mem_we_c && rst_ni) begin
      mem_q[op_idx_c] <= op_wdata_c;
    end
  end

  assign ready_o    = ready_q;
  assign ack_o      = ack_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Randomised and directed checks of dmem_wait_responder against a transaction-level
// memory model, on a LATENCY=2 instance and a LATENCY=0/CNTW=2 instance.
`timescale 1ns/1ps

module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic        cur;
  logic        req, we;
  logic [31:0] addr, wdata;

  logic        ready_a, ack_a, err_a, ready_b, ack_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  dmem_wait_responder #(.DEPTH(64), .LATENCY(2), .CNTW(16)) u_a (
    .clk_i(clk), .rst_ni(rst_a_n), .req_i(req & ~cur), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready_a), .ack_o(ack_a), .err_o(err_a),
    .rdata_o(rdata_a), .wr_count_o(cnt_a)
  );

  dmem_wait_responder #(.DEPTH(16), .LATENCY(0), .CNTW(2)) u_b (
    .clk_i(clk), .rst_ni(rst_b_n), .req_i(req & cur), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready_b), .ack_o(ack_b), .err_o(err_b),
    .rdata_o(rdata_b), .wr_count_o(cnt_b)
  );

  logic        rdy, ack, err;
  logic [31:0] rdata, cnt;
  assign rdy   = cur ? ready_b : ready_a;
  assign ack   = cur ? ack_b   : ack_a;
  assign err   = cur ? err_b   : err_a;
  assign rdata = cur ? rdata_b : rdata_a;
  assign cnt   = cur ? {30'd0, cnt_b} : {16'd0, cnt_a};

  logic [31:0] model_mem [2][64];
  int unsigned model_cnt [2];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned lat_of(input logic s);
    return s ? 0 : 2;
  endfunction
  function automatic int unsigned depth_of(input logic s);
    return s ? 16 : 64;
  endfunction
  function automatic int unsigned cmax_of(input logic s);
    return s ? 3 : 65535;
  endfunction

  // one request from an idle responder; checks latency, payload and pulse width
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    int unsigned edges, budget, idx;
    logic        legal;
    logic [31:0] exp_r;
    budget = 0;
    while (!rdy && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("ready_before_req", 32'(rdy), 32'd1);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
    edges = 1;
    while (!ack && edges < 12) begin
      @(negedge clk);
      edges++;
    end
    idx   = a >> 2;
    legal = (a % 4 == 0) && (idx < depth_of(cur));
    exp_r = (legal && !w) ? model_mem[cur][idx] : 32'd0;
    if (legal && w) begin
      model_mem[cur][idx] = d;
      if (model_cnt[cur] < cmax_of(cur)) model_cnt[cur]++;
    end
    chk("ack_latency", edges, lat_of(cur) + 1);
    chk("err", 32'(err), 32'(!legal));
    chk("rdata", rdata, exp_r);
    chk("wr_count", cnt, model_cnt[cur]);
    chk("ready_in_resp", 32'(rdy), 32'd0);
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack), 32'd0);
    chk("ready_after", 32'(rdy), 32'd1);
    chk("rdata_idle", rdata, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    if (cur) rst_b_n = 1'b0; else rst_a_n = 1'b0;
    #1;
    chk("rst_ready", 32'(rdy), 32'd1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    model_cnt[cur] = 0;
    @(negedge clk);
    if (cur) rst_b_n = 1'b1; else rst_a_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr(input int unsigned depth);
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0, 1:    a = 32'($urandom_range(0, depth - 1)) * 32'd4;
      2:       a = (32'($urandom_range(0, depth - 1)) * 32'd4) | 32'($urandom_range(1, 3));
      default: a = ($urandom_range(0, 1) != 0) ? (32'(depth) + 32'($urandom_range(0, 7))) * 32'd4
                                                : ($urandom | 32'h8000_0000);
    endcase
    return a;
  endfunction

  task automatic rand_txns(input int n);
    for (int i = 0; i < n; i++) begin
      do_txn(1'($urandom), rand_addr(depth_of(cur)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    int unsigned p, nstream, last_acc, nacc;
    logic [31:0] base;
    cur = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    model_cnt[0] = 0; model_cnt[1] = 0;
    #12;
    for (int s = 0; s < 2; s++) begin
      cur = 1'(s);
      #1;
      chk("por_ready", 32'(rdy), 32'd1);
      chk("por_ack", 32'(ack), 32'd0);
      chk("por_err", 32'(err), 32'd0);
      chk("por_rdata", rdata, 32'd0);
      chk("por_cnt", cnt, 32'd0);
    end
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    // give both memories known (zero) contents, then clear the counters
    for (int s = 0; s < 2; s++) begin
      cur = 1'(s);
      for (int i = 0; i < int'(depth_of(cur)); i++) do_txn(1'b1, 32'(i * 4), 32'd0);
      do_reset();
    end

    cur = 1'b0;
    do_txn(1'b1, 32'd84, 32'd7);
    chk("first_write_cnt", cnt, 32'd1);
    do_txn(1'b0, 32'd84, 32'd0);
    do_txn(1'b0, 32'd80, 32'd0);
    do_txn(1'b1, 32'd86, 32'hDEAD);
    do_txn(1'b1, 32'd256, 32'hDEAD);
    chk("err_cnt_unchanged", cnt, 32'd1);
    do_txn(1'b0, 32'd84, 32'd0);

    // req held high: accepts every LATENCY+2 edges, data taken on accept edges only
    p = lat_of(cur) + 2;
    nstream = 22;
    base = 32'h1000;
    nacc = 0;
    last_acc = 0;
    for (int unsigned n = 1; n <= nstream; n++) begin
      req = 1'b1; we = 1'b1; addr = 32'd4; wdata = base + 32'(n);
      if ((n - 1) % p == 0) begin
        nacc++;
        last_acc = n;
      end
      @(negedge clk);
      chk("stream_ack", 32'(ack), 32'(((n - 1) % p) == lat_of(cur)));
      chk("stream_ready", 32'(rdy), 32'(((n - 1) % p) == p - 1));
    end
    req = 1'b0;
    model_mem[0][1] = base + 32'(last_acc);
    model_cnt[0] += nacc;
    repeat (4) @(negedge clk);
    chk("stream_cnt", cnt, model_cnt[0]);
    do_txn(1'b0, 32'd4, 32'd0);

    rand_txns(40);

    // reset one edge after accepting a write must abort it
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'd8; wdata = 32'h55;
    @(negedge clk);
    req = 1'b0;
    chk("abort_busy", 32'(rdy), 32'd0);
    rst_a_n = 1'b0;
    #1;
    chk("abort_ready", 32'(rdy), 32'd1);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_cnt", cnt, 32'd0);
    model_cnt[0] = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(ack), 32'd0);
      rst_a_n = 1'b1;
    end
    do_txn(1'b0, 32'd8, 32'd0);
    chk("abort_cnt_after", cnt, 32'd0);

    cur = 1'b1;
    do_txn(1'b1, 32'd0, 32'd9);
    do_txn(1'b0, 32'd0, 32'd0);
    chk("l0_rdata_direct", model_mem[1][0], 32'd9);
    for (int i = 0; i < 5; i++) do_txn(1'b1, 32'(4 * (i + 1)), $urandom);
    chk("cnt_saturated", cnt, 32'd3);
    rand_txns(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
